lsp_prev_extract: RTL and testbench

LSP_PREV_EXTRACT -- requirements
Module: lsp_prev_extract

---
 rtl/lsp_prev_extract.sv | 162 ++++++++++++++++
 tb/tb_lsp_prev_extract.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsp_prev_extract.sv
// Inverse of the LSP MA-prediction step: for each of 10 coefficients, removes the
// four weighted previous-frame contributions and rescales by fg_sum_inv (G.729 basic-op semantics).
module lsp_prev_extract (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] lspAddr,
    input  logic [11:0] freq_prevAddr,
    input  logic [11:0] fgAddr,
    input  logic [11:0] fg_sum_invAddr,
    input  logic [11:0] lsp_eleAddr,
    input  logic [31:0] memIn,
    input  logic [31:0] constantMemIn,
    output logic [11:0] memReadAddr,
    output logic [11:0] memWriteAddr,
    output logic [31:0] memOut,
    output logic        memWriteEn,
    output logic [11:0] constantMemAddr,
    output logic        done,
    output logic [2:0]  o_dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_LSP = 3'd1;
    localparam logic [2:0] S_INIT   = 3'd2;
    localparam logic [2:0] S_MSU    = 3'd3;
    localparam logic [2:0] S_MULT   = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]  r_state;
    logic [3:0]  r_j;
    logic [1:0]  r_k;
    logic [31:0] r_acc;
    logic [15:0] r_res;

    function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        // Only -1 * -1 overflows the doubled product.
        if (p == 32'sh4000_0000) return 32'h7FFF_FFFF;
        return {p[30:0], 1'b0};
    endfunction

    function automatic logic [31:0] l_sub(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        d = {a[31], a} - {b[31], b};
        if (d[32] != d[31]) return d[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return d[31:0];
    endfunction

    function automatic logic [31:0] l_shl3(input logic [31:0] x);
        if (x[31:28] == 4'h0 || x[31:28] == 4'hF) return {x[28:0], 3'b000};
        return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    logic [11:0] w_j12;
    logic [1:0]  w_row;
    logic [11:0] w_row_base;
    logic [11:0] w_off;
    logic [31:0] w_msu;
    logic [31:0] w_shl;
    logic        w_unused;

    assign w_j12 = {8'd0, r_j};
    // INIT fetches row 0; each MSU cycle prefetches the next row.
    assign w_row = (r_state == S_INIT) ? 2'd0 : (r_k + 2'd1);

    always_comb begin
        w_row_base = 12'd0;
        case (w_row)
            2'd0: w_row_base = 12'd0;
            2'd1: w_row_base = 12'd10;
            2'd2: w_row_base = 12'd20;
            2'd3: w_row_base = 12'd30;
            default: w_row_base = 12'd0;
        endcase
    end

    assign w_off    = w_row_base + w_j12;
    assign w_msu    = l_sub(r_acc, l_mult(memIn[15:0], constantMemIn[15:0]));
    assign w_shl    = l_shl3(l_mult(r_acc[31:16], constantMemIn[15:0]));
    assign w_unused = ^{memIn[31:16], constantMemIn[31:16], w_shl[15:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_j     <= 4'd0;
            r_k     <= 2'd0;
            r_acc   <= 32'd0;
            r_res   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RD_LSP;
                        r_j     <= 4'd0;
                    end
                end
                S_RD_LSP: r_state <= S_INIT;
                S_INIT: begin
                    r_acc   <= {memIn[15:0], 16'h0000};
                    r_k     <= 2'd0;
                    r_state <= S_MSU;
                end
                S_MSU: begin
                    r_acc <= w_msu;
                    if (r_k == 2'd3) r_state <= S_MULT;
                    else             r_k     <= r_k + 2'd1;
                end
                S_MULT: begin
                    r_res   <= w_shl[31:16];
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_j == 4'd9) begin
                        r_state <= S_DONE;
                    end else begin
                        r_j     <= r_j + 4'd1;
                        r_state <= S_RD_LSP;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        memReadAddr     = 12'd0;
        constantMemAddr = 12'd0;
        memWriteAddr    = 12'd0;
        memOut          = 32'd0;
        memWriteEn      = 1'b0;
        done            = 1'b0;
        case (r_state)
            S_RD_LSP: memReadAddr = lspAddr + w_j12;
            S_INIT: begin
                memReadAddr     = freq_prevAddr + w_off;
                constantMemAddr = fgAddr + w_off;
            end
            S_MSU: begin
                if (r_k == 2'd3) begin
                    constantMemAddr = fg_sum_invAddr + w_j12;
                end else begin
                    memReadAddr     = freq_prevAddr + w_off;
                    constantMemAddr = fgAddr + w_off;
                end
            end
            S_WRITE: begin
                memWriteEn   = 1'b1;
                memWriteAddr = lsp_eleAddr + w_j12;
                memOut       = {{16{r_res[15]}}, r_res};
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsp_prev_extract.sv
// Bench for lsp_prev_extract: memory models, table vectors, random jobs vs an arithmetic model,
// plus reset-abort, ignored-start and address-wrap sequences.
module tb_lsp_prev_extract;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] lspAddr, freq_prevAddr, fgAddr, fg_sum_invAddr, lsp_eleAddr;
    logic [31:0] memIn = 32'd0, constantMemIn = 32'd0;
    logic [11:0] memReadAddr, memWriteAddr, constantMemAddr;
    logic [31:0] memOut;
    logic        memWriteEn, done;
    logic [2:0]  o_dbg_state;

    lsp_prev_extract dut (
        .clk(clk), .reset(reset), .start(start),
        .lspAddr(lspAddr), .freq_prevAddr(freq_prevAddr), .fgAddr(fgAddr),
        .fg_sum_invAddr(fg_sum_invAddr), .lsp_eleAddr(lsp_eleAddr),
        .memIn(memIn), .constantMemIn(constantMemIn),
        .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr), .memOut(memOut),
        .memWriteEn(memWriteEn), .constantMemAddr(constantMemAddr), .done(done),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one-cycle read latency.
    logic [31:0] smem [4096];
    logic [31:0] cmem [4096];
    always @(posedge clk) begin
        memIn         <= smem[memReadAddr];
        constantMemIn <= cmem[constantMemAddr];
        if (memWriteEn) smem[memWriteAddr] <= memOut;
    end

    logic [43:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------------
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 64'sd1;

    function automatic longint sat32(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic longint s16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint lmult_m(input longint a, input longint b);
        return sat32(2 * a * b);
    endfunction

    function automatic logic [31:0] model_elem(input int j);
        longint acc, hi, p;
        logic [11:0] a;
        a   = lspAddr + 12'(j);
        acc = s16(smem[a][15:0]) * 65536;
        for (int k = 0; k < 4; k++) begin
            logic [11:0] fa, ga;
            fa  = freq_prevAddr + 12'(10 * k + j);
            ga  = fgAddr + 12'(10 * k + j);
            acc = sat32(acc - lmult_m(s16(smem[fa][15:0]), s16(cmem[ga][15:0])));
        end
        hi = acc >>> 16;
        a  = fg_sum_invAddr + 12'(j);
        p  = sat32(lmult_m(hi, s16(cmem[a][15:0])) * 8);
        return 32'(p >>> 16);
    endfunction

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic [15:0]       lsp;
        logic [3:0][15:0]  fp;
        logic [3:0][15:0]  fg;
        logic [15:0]       fsi;
        logic [15:0]       res;
    } vec_t;

    vec_t tbl[6];

    function automatic vec_t mk(input logic [15:0] lsp,
                                input logic [15:0] f0, f1, f2, f3,
                                input logic [15:0] g0, g1, g2, g3,
                                input logic [15:0] fsi, res);
        vec_t v;
        v.lsp = lsp;
        v.fp[0] = f0; v.fp[1] = f1; v.fp[2] = f2; v.fp[3] = f3;
        v.fg[0] = g0; v.fg[1] = g1; v.fg[2] = g2; v.fg[3] = g3;
        v.fsi = fsi;
        v.res = res;
        return v;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_bases(input logic [11:0] l, f, g, s, e);
        lspAddr = l; freq_prevAddr = f; fgAddr = g; fg_sum_invAddr = s; lsp_eleAddr = e;
    endtask

    // Upper halves get junk: only bits [15:0] are operands.
    task automatic put(input bit cm, input logic [11:0] a, input logic [15:0] v);
        if (cm) cmem[a] = {16'($urandom), v};
        else    smem[a] = {16'($urandom), v};
    endtask

    task automatic fill_random();
        for (int j = 0; j < 10; j++) begin
            put(0, lspAddr + 12'(j), rnd16());
            put(1, fg_sum_invAddr + 12'(j), rnd16());
            for (int k = 0; k < 4; k++) begin
                put(0, freq_prevAddr + 12'(10 * k + j), rnd16());
                put(1, fgAddr + 12'(10 * k + j), rnd16());
            end
        end
    endtask

    task automatic load_model_exp();
        for (int j = 0; j < 10; j++) exp_q.push_back({lsp_eleAddr + 12'(j), model_elem(j)});
    endtask

    // Pulses start in the current cycle; cycle 1 is the first cycle after the accepting edge.
    task automatic run_job(input int rst_at, input int s1, input int s2, input int budget,
                           output int done_cyc, output int n_wr);
        int c;
        bit stop;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; done_cyc = -1; n_wr = 0; stop = 0;
        while (c <= budget && !stop) begin
            if (memWriteEn) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wr_unexpected: got write at %0h cycle %0d want none", memWriteAddr, c);
                end else begin
                    logic [43:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(memWriteAddr), 64'(e[43:32]));
                    check("wr_data", 64'(memOut), 64'(e[31:0]));
                    check("wr_cycle", 64'(c), 64'(8 + 8 * (n_wr - 1)));
                end
            end
            if (done) begin
                if (done_cyc == -1) done_cyc = c;
                else begin
                    n_tests++; n_fail++;
                    $display("FAIL done_twice: got second done at cycle %0d want one", c);
                end
            end
            start = (c == s1 || c == s2);
            reset = (c == rst_at);
            stop  = (done_cyc != -1) || (c == rst_at);
            @(posedge clk); #1;
            start = 1'b0;
            reset = 1'b0;
            c++;
        end
    endtask

    task automatic full_job(input string tag);
        int dc, nw;
        run_job(-1, -1, -1, 100, dc, nw);
        check({tag, "_done_cycle"}, 64'(dc), 64'd81);
        check({tag, "_n_writes"}, 64'(nw), 64'd10);
        check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_wen"}, 64'(memWriteEn), 64'd0);
        check({tag, "_raddr"}, 64'(memReadAddr), 64'd0);
        check({tag, "_waddr"}, 64'(memWriteAddr), 64'd0);
        check({tag, "_mout"}, 64'(memOut), 64'd0);
        check({tag, "_caddr"}, 64'(constantMemAddr), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int dc, nw;
        logic [31:0] exp_arr[10];

        tbl[0] = mk(16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                    16'h1234, 16'h4321, 16'h7FFF, 16'h8000, 16'h1000, 16'h1000);
        tbl[1] = mk(16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                    16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        tbl[2] = mk(16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000,
                    16'h8000, 16'h5555, 16'h5555, 16'h5555, 16'h8000, 16'h7FFF);
        tbl[3] = mk(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                    16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h4000, 16'h8000);
        tbl[4] = mk(16'h0100, 16'h0010, 16'h0000, 16'h0000, 16'h0000,
                    16'h0100, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0800, 16'h007F);
        tbl[5] = mk(16'hFF00, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                    16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h1000, 16'hFEF8);

        for (int i = 0; i < 4096; i++) begin
            smem[i] = 32'd0;
            cmem[i] = 32'd0;
        end

        // Clock/reset.
        reset = 1'b1;
        start = 1'b0;
        set_bases(12'h100, 12'h200, 12'h100, 12'h200, 12'h400);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_outputs("rst_init");
        check("rst_init_state", 64'(o_dbg_state), 64'd0);

        // Table vectors: element j takes record j mod 6.
        for (int j = 0; j < 10; j++) begin
            vec_t v;
            v = tbl[j % 6];
            put(0, lspAddr + 12'(j), v.lsp);
            put(1, fg_sum_invAddr + 12'(j), v.fsi);
            for (int k = 0; k < 4; k++) begin
                put(0, freq_prevAddr + 12'(10 * k + j), v.fp[k]);
                put(1, fgAddr + 12'(10 * k + j), v.fg[k]);
            end
            exp_q.push_back({lsp_eleAddr + 12'(j), {{16{v.res[15]}}, v.res}});
        end
        full_job("table");

        // Random jobs against the model.
        for (int n = 0; n < 20; n++) begin
            set_bases(12'h100 + 12'($urandom_range(0, 15)), 12'h200 + 12'($urandom_range(0, 15)),
                      12'h100 + 12'($urandom_range(0, 15)), 12'h200 + 12'($urandom_range(0, 15)),
                      12'h400 + 12'($urandom_range(0, 15)));
            fill_random();
            load_model_exp();
            full_job("rand");
        end

        // Address wrap on both the write window and a constant-memory read window.
        set_bases(12'h123, 12'h280, 12'hFF8, 12'h300, 12'hFFC);
        fill_random();
        load_model_exp();
        full_job("wrap");

        // Reset in cycle 30: elements 0..2 land, 3..9 keep their sentinels.
        set_bases(12'h100, 12'h200, 12'h100, 12'h200, 12'h500);
        fill_random();
        for (int j = 0; j < 10; j++) begin
            smem[lsp_eleAddr + 12'(j)] = 32'hDEAD_0000 | 32'(j);
            exp_arr[j] = model_elem(j);
            exp_q.push_back({lsp_eleAddr + 12'(j), exp_arr[j]});
        end
        run_job(30, -1, -1, 100, dc, nw);
        exp_q.delete();
        check_reset_outputs("rst_mid");
        check("rst_mid_state", 64'(o_dbg_state), 64'd0);
        check("rst_mid_n_writes", 64'(nw), 64'd3);
        check("rst_mid_no_done", 64'(dc), 64'hFFFF_FFFF_FFFF_FFFF);
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 10; i++) begin
                if (memWriteEn || done) extra++;
                @(posedge clk); #1;
            end
            check("rst_mid_quiet", 64'(extra), 64'd0);
        end
        for (int j = 0; j < 10; j++)
            check("rst_mid_mem", 64'(smem[lsp_eleAddr + 12'(j)]),
                  64'(j < 3 ? exp_arr[j] : (32'hDEAD_0000 | 32'(j))));
        load_model_exp();
        full_job("after_rst");

        // Starts in cycles 5 and 81 are ignored; a start in cycle 82 is accepted.
        set_bases(12'h140, 12'h240, 12'h140, 12'h240, 12'h600);
        fill_random();
        load_model_exp();
        run_job(-1, 5, 81, 100, dc, nw);
        check("ign_done_cycle", 64'(dc), 64'd81);
        check("ign_n_writes", 64'(nw), 64'd10);
        exp_q.delete();
        check("ign_idle_state", 64'(o_dbg_state), 64'd0);
        check("ign_idle_raddr", 64'(memReadAddr), 64'd0);
        load_model_exp();
        full_job("start82");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
